// File: rtl/fp_cvt.sv
// Purpose: convert a 12-bit two's-complement integer to an 8-bit sign/exponent/significand code.
// Latency: 1 cycle; D sampled on rising clk, S/E/F hold that conversion until the next edge.
// Backpressure: none; one conversion accepted and produced every cycle, no handshake.
module fp_cvt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] D,
    output logic        S,
    output logic [2:0]  E,
    output logic [3:0]  F
);

    // Combinational conversion path
    logic        w_sign;
    logic [11:0] w_mag;
    logic        w_min_neg;
    logic [3:0]  w_msb;
    logic [3:0]  w_e0;
    logic [3:0]  w_f0;
    logic [12:0] w_mag_ext;
    logic        w_rnd;
    logic [2:0]  w_e;
    logic [3:0]  w_f;

    // Registered result
    logic        r_s;
    logic [2:0]  r_e;
    logic [3:0]  r_f;

    assign w_sign    = D[11];
    assign w_mag     = w_sign ? (~D + 12'd1) : D;
    // -2048 has no positive 12-bit counterpart; its magnitude wraps to 0x800
    assign w_min_neg = (D == 12'h800);

    // Position of the most significant set bit of the magnitude (0 when mag is 0 or 1)
    always_comb begin
        w_msb = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (w_mag[i]) begin
                w_msb = 4'(i);
            end
        end
    end

    // Exponent puts the leading one at significand bit 3; small values stay denormal at E0=0.
    // This equals 8 - leading_zeros for the normalised range.
    assign w_e0 = (w_msb >= 4'd4) ? (w_msb - 4'd3) : 4'd0;

    // Significand is the 4-bit window starting at bit E0
    assign w_f0 = 4'(w_mag >> w_e0);

    // Rounding bit is the bit just below the window; the appended zero covers E0 = 0
    assign w_mag_ext = {w_mag, 1'b0};
    assign w_rnd     = 1'(w_mag_ext >> w_e0);

    // Round to nearest (ties up in magnitude), renormalise on significand overflow, saturate at the top code
    always_comb begin
        w_e = w_e0[2:0];
        w_f = w_f0;
        if (w_min_neg) begin
            w_e = 3'd7;
            w_f = 4'd15;
        end else if (w_rnd) begin
            if (w_f0 != 4'd15) begin
                w_f = w_f0 + 4'd1;
            end else if (w_e0 < 4'd7) begin
                w_f = 4'd8;
                w_e = w_e0[2:0] + 3'd1;
            end else begin
                w_f = 4'd15;
                w_e = 3'd7;
            end
        end
    end

    // Output register; reset clears immediately regardless of clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s <= 1'b0;
            r_e <= 3'd0;
            r_f <= 4'd0;
        end else begin
            r_s <= w_sign;
            r_e <= w_e;
            r_f <= w_f;
        end
    end

    assign S = r_s;
    assign E = r_e;
    assign F = r_f;

endmodule

// File: tb/tb_fp_cvt.sv
// Purpose: directed and sweep checks of fp_cvt against an independent rounding model.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: none; the bench drives one value per cycle.
module tb_fp_cvt;

    logic        clk;
    logic        rst_n;
    logic [11:0] D;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;

    int n_chk;
    int n_pass;

    fp_cvt u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .D     (D),
        .S     (S),
        .E     (E),
        .F     (F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: arithmetic round-half-up of mag / 2^E, returns {S,E[2:0],F[3:0]}
    function automatic logic [7:0] ref_cvt(input int d);
        int  m;
        int  e;
        int  f;
        logic s;
        s = (d < 0);
        m = (d < 0) ? -d : d;
        if (d == -2048) begin
            e = 7;
            f = 15;
        end else if (m < 16) begin
            e = 0;
            f = m;
        end else begin
            e = 0;
            while (m >= (16 << e)) e++;
            f = (m + (1 << (e - 1))) >> e;
            if (f == 16) begin
                f = 8;
                e = e + 1;
            end
            if (e > 7) begin
                e = 7;
                f = 15;
            end
        end
        return {s, 3'(e), 4'(f)};
    endfunction

    // Drive one value, let it through the register, sample after the edge
    task automatic apply(input int d);
        D = 12'(d);
        @(posedge clk);
        #1;
    endtask

    logic [7:0] got;
    logic [7:0] pos_ef;
    int         val;
    int         err;
    int         mag;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        D      = 12'h7FF;

        // Reset holds outputs at zero across clock edges
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold", {S, E, F}, 8'h00);
        @(posedge clk);
        #1;
        chk("reset_hold2", {S, E, F}, 8'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_release", {S, E, F}, {1'b0, 3'd7, 4'd15});

        // Directed vectors, hand-computed
        apply(0);     chk("d0",     {S, E, F}, {1'b0, 3'd0, 4'd0});
        apply(1);     chk("d1",     {S, E, F}, {1'b0, 3'd0, 4'd1});
        apply(2);     chk("d2",     {S, E, F}, {1'b0, 3'd0, 4'd2});
        apply(512);   chk("d512",   {S, E, F}, {1'b0, 3'd6, 4'd8});
        apply(-422);  chk("dm422",  {S, E, F}, {1'b1, 3'd5, 4'd13});
        apply(125);   chk("d125",   {S, E, F}, {1'b0, 3'd4, 4'd8});
        apply(2046);  chk("d2046",  {S, E, F}, {1'b0, 3'd7, 4'd15});
        apply(2047);  chk("d2047",  {S, E, F}, {1'b0, 3'd7, 4'd15});
        apply(-2048); chk("dm2048", {S, E, F}, {1'b1, 3'd7, 4'd15});
        apply(24);    chk("d24_tie",  {S, E, F}, {1'b0, 3'd1, 4'd12});
        apply(17);    chk("d17_tie",  {S, E, F}, {1'b0, 3'd1, 4'd9});
        apply(31);    chk("d31_ovf",  {S, E, F}, {1'b0, 3'd2, 4'd8});
        apply(15);    chk("d15",      {S, E, F}, {1'b0, 3'd0, 4'd15});
        apply(-1983); chk("dm1983",   {S, E, F}, {1'b1, 3'd7, 4'd15});
        apply(1984);  chk("d1984_sat",{S, E, F}, {1'b0, 3'd7, 4'd15});

        // Changes between edges must not reach the outputs
        apply(100);
        D = 12'h7FF;
        #3;
        chk("settle_hold", {S, E, F}, {1'b0, 3'd3, 4'd13});

        // Sweep: model, sign, symmetry and error bound
        for (int d = 1; d <= 2047; d++) begin
            apply(d);
            got    = {S, E, F};
            pos_ef = got;
            chk("sweep_pos", got, ref_cvt(d));
            val = int'(F) << int'(E);
            err = (val > d) ? (val - d) : (d - val);
            if (d < 1984) begin
                chk("sweep_err", (2 * err) <= (1 << int'(E)), 1);
            end
            apply(-d);
            got = {S, E, F};
            chk("sweep_sign", S, 1'b1);
            chk("sweep_sym", got[6:0], pos_ef[6:0]);
            chk("sweep_neg", got, ref_cvt(-d));
        end

        // Async reset between edges while streaming
        for (int k = 0; k < 20; k++) begin
            mag = $urandom_range(4095);
            apply(mag - 2048);
            chk("stream", {S, E, F}, ref_cvt(mag - 2048));
            if (k % 5 == 4) begin
                #1;
                rst_n = 1'b0;
                #1;
                chk("async_rst", {S, E, F}, 8'h00);
                #1;
                rst_n = 1'b1;
                #1;
                chk("async_rst_hold", {S, E, F}, 8'h00);
            end
        end
        apply(-422);
        chk("resume", {S, E, F}, {1'b1, 3'd5, 4'd13});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Safety bound so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
